// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared 4-bit ALU,
// with a single registered response slot and a consumed-response counter.
module alu_arbiter #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_func,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_func,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_result,
    output logic       rsp_z,
    output logic       rsp_l,
    output logic [7:0] ops_done
);

    logic       prio;
    logic       grant0;
    logic       grant1;
    logic       slot_free;
    logic       accept;
    logic       consume;
    logic       both;
    logic [2:0] alu_func;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_res;
    logic       alu_z;
    logic       alu_l;

    assign both      = req0_valid && req1_valid;
    assign grant0    = req0_valid && (!req1_valid || !prio);
    assign grant1    = req1_valid && (!req0_valid || prio);
    assign slot_free = !rsp_valid || rsp_ready;

    // Readies are forced low while reset is asserted.
    assign req0_ready = rst_n && slot_free && grant0;
    assign req1_ready = rst_n && slot_free && grant1;

    assign accept  = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign consume = rsp_valid && rsp_ready;

    assign alu_func = grant1 ? req1_func : req0_func;
    assign alu_a    = grant1 ? req1_a    : req0_a;
    assign alu_b    = grant1 ? req1_b    : req0_b;

    always_comb begin
        alu_res = 4'h0;
        alu_z   = 1'b0;
        alu_l   = 1'b0;
        unique case (alu_func)
            3'd0: alu_res = alu_a + alu_b;
            3'd1: alu_res = alu_a - alu_b;
            3'd2: alu_res = ~alu_a;
            3'd3: alu_res = alu_a & alu_b;
            3'd4: alu_res = alu_a | alu_b;
            3'd5: alu_res = alu_a ^ alu_b;
            3'd6: alu_l   = (alu_a < alu_b);
            3'd7: alu_z   = (alu_a == alu_b);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= 4'h0;
            rsp_z      <= 1'b0;
            rsp_l      <= 1'b0;
            ops_done   <= 8'h00;
            prio       <= PRIO_INIT;
        end else begin
            if (accept) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= grant1;
                rsp_result <= alu_res;
                rsp_z      <= alu_z;
                rsp_l      <= alu_l;
            end else if (consume) begin
                rsp_valid <= 1'b0;
            end
            if (consume) begin
                ops_done <= ops_done + 8'd1;
            end
            // Only a contested grant hands priority to the other side.
            if (accept && both) begin
                prio <= ~prio;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table plus hand sequences,
// responses checked through an expected-result queue.
module tb_alu_arbiter;

    typedef struct {
        logic       id;
        logic [2:0] f;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r;
        logic       z;
        logic       l;
    } vec_t;

    typedef struct {
        logic       id;
        logic [3:0] r;
        logic       z;
        logic       l;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid;
    logic       req0_ready;
    logic [2:0] req0_func;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic       req1_valid;
    logic       req1_ready;
    logic [2:0] req1_func;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [3:0] rsp_result;
    logic       rsp_z;
    logic       rsp_l;
    logic [7:0] ops_done;

    int checks = 0;
    int passed = 0;

    rsp_t       sbq[$];
    rsp_t       e0;
    rsp_t       e1;
    logic       prio_m;
    logic       vld_m;
    logic [7:0] ops_m;
    logic [1:0] last_acc;
    vec_t       tbl[14];

    alu_arbiter #(.PRIO_INIT(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_func (req0_func),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_func (req1_func),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_result(rsp_result),
        .rsp_z     (rsp_z),
        .rsp_l     (rsp_l),
        .ops_done  (ops_done)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic set0(logic v, logic [2:0] f, logic [3:0] a, logic [3:0] b);
        req0_valid = v;
        req0_func  = f;
        req0_a     = a;
        req0_b     = b;
    endtask

    task automatic set1(logic v, logic [2:0] f, logic [3:0] a, logic [3:0] b);
        req1_valid = v;
        req1_func  = f;
        req1_a     = a;
        req1_b     = b;
    endtask

    // Called at a negedge with inputs already driven; ends at next negedge.
    task automatic cyc();
        logic slot;
        logic g0;
        logic g1;
        logic a0;
        logic a1;
        logic cons;
        rsp_t ex;
        #1;
        slot = !vld_m || rsp_ready;
        g0   = req0_valid && (!req1_valid || !prio_m);
        g1   = req1_valid && (!req0_valid || prio_m);
        a0   = slot && g0;
        a1   = slot && g1;
        cons = vld_m && rsp_ready;
        chk("req0_ready", req0_ready, a0);
        chk("req1_ready", req1_ready, a1);
        chk("rsp_valid", rsp_valid, vld_m);
        if (vld_m && sbq.size() > 0) begin
            ex = sbq[0];
            chk("rsp_id", rsp_id, ex.id);
            chk("rsp_result", rsp_result, ex.r);
            chk("rsp_z", rsp_z, ex.z);
            chk("rsp_l", rsp_l, ex.l);
        end
        if (cons) begin
            if (sbq.size() == 0) begin
                checks++;
                $display("FAIL sb_empty: got response, expected none");
            end else begin
                void'(sbq.pop_front());
            end
            ops_m = ops_m + 8'd1;
        end
        if (a0) sbq.push_back(e0);
        if (a1) sbq.push_back(e1);
        if ((a0 || a1) && req0_valid && req1_valid) prio_m = !prio_m;
        if (a0 || a1) vld_m = 1'b1;
        else if (cons) vld_m = 1'b0;
        last_acc = {a1, a0};
        @(posedge clk);
        @(negedge clk);
        chk("ops_done", ops_done, ops_m);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set0(1'b1, 3'd0, 4'h1, 4'h1);
        set1(1'b1, 3'd0, 4'h2, 4'h2);
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_z", rsp_z, 0);
        chk("rst_rsp_l", rsp_l, 0);
        chk("rst_ops_done", ops_done, 0);
        sbq.delete();
        prio_m = 1'b0;
        vld_m  = 1'b0;
        ops_m  = 8'h00;
        rst_n  = 1'b1;
        set0(1'b0, 3'd0, 4'h0, 4'h0);
        set1(1'b0, 3'd0, 4'h0, 4'h0);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 3'd0, 4'hF, 4'h1, 4'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 3'd1, 4'h0, 4'h1, 4'hF, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 3'd2, 4'h5, 4'h3, 4'hA, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 3'd3, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 3'd4, 4'hC, 4'hA, 4'hE, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 3'd5, 4'hC, 4'hA, 4'h6, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 3'd6, 4'h2, 4'h9, 4'h0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 3'd6, 4'h9, 4'h2, 4'h0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 3'd7, 4'h7, 4'h7, 4'h0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 3'd7, 4'h7, 4'h6, 4'h0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 3'd0, 4'h9, 4'h8, 4'h1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 3'd1, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 3'd6, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 3'd0, 4'h7, 4'h7, 4'hE, 1'b0, 1'b0};

        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        set0(1'b0, 3'd0, 4'h0, 4'h0);
        set1(1'b0, 3'd0, 4'h0, 4'h0);
        @(negedge clk);
        do_reset();

        // Table: single-requester ops back to back, consumer always ready.
        rsp_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].id == 1'b0) begin
                set0(1'b1, tbl[i].f, tbl[i].a, tbl[i].b);
                set1(1'b0, 3'($urandom_range(7)), 4'h3, 4'h4);
            end else begin
                set1(1'b1, tbl[i].f, tbl[i].a, tbl[i].b);
                set0(1'b0, 3'($urandom_range(7)), 4'h3, 4'h4);
            end
            e0 = '{1'b0, tbl[i].r, tbl[i].z, tbl[i].l};
            e1 = '{1'b1, tbl[i].r, tbl[i].z, tbl[i].l};
            cyc();
            chk("accept_each_cycle", last_acc != 2'b00, 1);
        end
        set0(1'b0, 3'd0, 4'h0, 4'h0);
        set1(1'b0, 3'd0, 4'h0, 4'h0);
        cyc();
        chk("table_drained", sbq.size(), 0);
        chk("table_ops_done", ops_done, 14);

        // Held response blocks both requesters.
        set1(1'b1, 3'd6, 4'h2, 4'h9);
        e1 = '{1'b1, 4'h0, 1'b0, 1'b1};
        cyc();
        rsp_ready = 1'b0;
        set0(1'b1, 3'd0, 4'h1, 4'h2);
        set1(1'b1, 3'd3, 4'hF, 4'h0);
        e0 = '{1'b0, 4'h3, 1'b0, 1'b0};
        e1 = '{1'b1, 4'h0, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_valid", rsp_valid, 1);
            chk("hold_result", rsp_result, 0);
            chk("hold_l", rsp_l, 1);
            chk("hold_no_accept", last_acc, 0);
        end
        rsp_ready = 1'b1;
        set0(1'b0, 3'd0, 4'h0, 4'h0);
        set1(1'b0, 3'd0, 4'h0, 4'h0);
        cyc();
        cyc();
        chk("hold_released", rsp_valid, 0);

        // Contention from reset: grants alternate starting with requester 0.
        do_reset();
        rsp_ready = 1'b1;
        set0(1'b1, 3'd1, 4'h0, 4'h1);
        set1(1'b1, 3'd7, 4'h5, 4'h5);
        e0 = '{1'b0, 4'hF, 1'b0, 1'b0};
        e1 = '{1'b1, 4'h0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("alt_grant", last_acc, (i % 2 == 1) ? 2 : 1);
        end
        set0(1'b0, 3'd0, 4'h0, 4'h0);
        set1(1'b0, 3'd0, 4'h0, 4'h0);
        cyc();

        // Reset with a pending response and priority moved to requester 1.
        rsp_ready = 1'b0;
        set0(1'b1, 3'd0, 4'h4, 4'h4);
        set1(1'b1, 3'd0, 4'h5, 4'h5);
        e0 = '{1'b0, 4'h8, 1'b0, 1'b0};
        e1 = '{1'b1, 4'hA, 1'b0, 1'b0};
        cyc();
        chk("pre_reset_valid", rsp_valid, 1);
        do_reset();
        rsp_ready = 1'b1;
        set0(1'b1, 3'd4, 4'h1, 4'h2);
        set1(1'b1, 3'd4, 4'h4, 4'h8);
        e0 = '{1'b0, 4'h3, 1'b0, 1'b0};
        e1 = '{1'b1, 4'hC, 1'b0, 1'b0};
        cyc();
        chk("prio_after_reset", last_acc, 1);
        set0(1'b0, 3'd0, 4'h0, 4'h0);
        set1(1'b0, 3'd0, 4'h0, 4'h0);
        cyc();

        // 256 consumes wrap the counter.
        do_reset();
        rsp_ready = 1'b1;
        set0(1'b1, 3'd0, 4'h1, 4'h1);
        e0 = '{1'b0, 4'h2, 1'b0, 1'b0};
        for (int i = 0; i < 256; i++) cyc();
        set0(1'b0, 3'd0, 4'h0, 4'h0);
        cyc();
        chk("ops_wrap", ops_done, 0);
        chk("final_drained", sbq.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
